// File: rtl/bcd_count_display_pkg.sv
// Shared definitions for the BCD counter / 7-segment display slice.
// Segment patterns are active-low and ordered {g,f,e,d,c,b,a}.
package bcd_count_display_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Codes 10..15 never occur in a BCD digit; they show as blank.
  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the up/down BCD counter; tc flags the digit value at which
// the next enabled count would roll over in the current direction.
module bcd_digit
  import bcd_count_display_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       clr,
  output logic [3:0] q,
  output logic       tc
);

  assign tc = up ? (q == BCD_MAX) : (q == BCD_MIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= BCD_MIN;
    end else if (clr) begin
      q <= BCD_MIN;
    end else if (en) begin
      if (up) begin
        q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
      end else begin
        q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_count_display.sv
// DIGITS-wide BCD up/down counter driven by a clock-enable strobe, shown on a
// multiplexed common-anode 7-segment display with leading-zero blanking.
module bcd_count_display
  import bcd_count_display_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 10000,
  parameter int BLANK_LZ = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CE,
  input  logic                  UP,
  input  logic                  CLR,
  output logic [4*DIGITS-1:0]   COUNT,
  output logic                  CARRY,
  output logic [DIGITS-1:0]     AN,
  output logic [6:0]            SEG,
  output logic                  DP
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // CE is a single-cycle strobe with no ready/backpressure: every rising
  // edge that samples CE=1 (and CLR=0) advances the count by exactly one.
  logic [DIGITS-1:0] dig_en;
  logic [DIGITS-1:0] dig_tc;
  logic [DIGITS-1:0] lz;

  always_comb begin
    logic chain;
    chain = CE;
    dig_en = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig_en[i] = chain;
      chain = chain & dig_tc[i];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk   (CLK),
      .rst_n (RST_N),
      .en    (dig_en[g]),
      .up    (UP),
      .clr   (CLR),
      .q     (COUNT[4*g +: 4]),
      .tc    (dig_tc[g])
    );
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CARRY <= 1'b0;
    end else begin
      CARRY <= !CLR && CE && (&dig_tc);
    end
  end

  // lz[i] is set when digit i and every digit above it are zero.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (COUNT[4*i +: 4] == BCD_MIN);
      lz[i] = all_zero;
    end
  end

  logic [DIV_W-1:0] scan_cnt;
  logic [IDX_W-1:0] scan_idx;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == DIV_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  logic [3:0]        cur_digit;
  logic              cur_blank;
  logic [DIGITS-1:0] an_next;
  logic [6:0]        seg_next;

  always_comb begin
    cur_digit = '0;
    cur_blank = 1'b0;
    an_next   = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx == IDX_W'(i)) begin
        cur_digit  = COUNT[4*i +: 4];
        cur_blank  = (BLANK_LZ != 0) && (i != 0) && lz[i];
        an_next[i] = 1'b0;
      end
    end
    seg_next = cur_blank ? SEG_BLANK : seg7_decode(cur_digit);
  end

  // AN and SEG share one register stage so the digit select and its pattern
  // always change on the same edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      AN  <= '1;
      SEG <= SEG_BLANK;
      DP  <= 1'b1;
    end else begin
      AN  <= an_next;
      SEG <= seg_next;
      DP  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_count_display.sv
// Bench for bcd_count_display: directed and random CE/UP/CLR traffic against
// an integer reference model, checked by a per-cycle scoreboard monitor.
module tb_bcd_count_display;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int MOD      = 10000;
  localparam int EW       = 1 + 4*DIGITS + DIGITS + 7;

  logic                CLK = 1'b0;
  logic                RST_N = 1'b0;
  logic                CE = 1'b0;
  logic                UP = 1'b1;
  logic                CLR = 1'b0;
  logic [4*DIGITS-1:0] COUNT;
  logic                CARRY;
  logic [DIGITS-1:0]   AN;
  logic [6:0]          SEG;
  logic                DP;

  bcd_count_display #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .BLANK_LZ (1)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CE    (CE),
    .UP    (UP),
    .CLR   (CLR),
    .COUNT (COUNT),
    .CARRY (CARRY),
    .AN    (AN),
    .SEG   (SEG),
    .DP    (DP)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model state ----------------
  int total_checks  = 0;
  int passed_checks = 0;
  logic [EW-1:0] exp_q[$];
  int model_val = 0;
  int edge_cnt  = 0;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs and queues what the outputs must be after the edge.
  task automatic step(input logic ce, input logic up, input logic clr);
    int idx, d;
    logic carry;
    logic [6:0] seg;
    logic [DIGITS-1:0] an;
    @(negedge CLK);
    CE = ce; UP = up; CLR = clr;
    edge_cnt++;
    idx = ((edge_cnt - 1) / SCAN_DIV) % DIGITS;
    d   = (model_val / pow10(idx)) % 10;
    seg = (idx > 0 && model_val < pow10(idx)) ? 7'h7F : seg_tab[d];
    an  = ~(DIGITS'(1) << idx);
    carry = 1'b0;
    if (clr) begin
      model_val = 0;
    end else if (ce) begin
      if (up) begin
        if (model_val == MOD - 1) begin model_val = 0; carry = 1'b1; end
        else model_val++;
      end else begin
        if (model_val == 0) begin model_val = MOD - 1; carry = 1'b1; end
        else model_val--;
      end
    end
    exp_q.push_back({carry, to_bcd(model_val), an, seg});
  endtask

  task automatic pulses(input int n, input logic up, input int max_gap);
    for (int i = 0; i < n; i++) begin
      step(1'b1, up, 1'b0);
      repeat ($urandom_range(0, max_gap)) step(1'b0, up, 1'b0);
    end
    step(1'b0, up, 1'b0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_count"}, 32'(COUNT), 32'h0);
    check({tag, "_carry"}, 32'(CARRY), 32'h0);
    check({tag, "_an"},    32'(AN),    32'hF);
    check({tag, "_seg"},   32'(SEG),   32'h7F);
    check({tag, "_dp"},    32'(DP),    32'h1);
  endtask

  task automatic settle();
    @(posedge CLK);
    #2;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [EW-1:0] mon_e;
  always @(posedge CLK) begin
    #1;
    if (RST_N && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("carry", 32'(CARRY), 32'(mon_e[EW-1]));
      check("count", 32'(COUNT), 32'(mon_e[EW-2 -: 4*DIGITS]));
      check("an",    32'(AN),    32'(mon_e[DIGITS+6 -: DIGITS]));
      check("seg",   32'(SEG),   32'(mon_e[6:0]));
      check("dp",    32'(DP),    32'h1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge CLK);
    #2;
    reset_checks("por");
    RST_N = 1'b1;

    // Twelve isolated up pulses.
    pulses(12, 1'b1, 3);
    settle();
    check("count_12", 32'(COUNT), 32'h0012);

    // Asynchronous reset in the middle of a count and a scan.
    pulses(5, 1'b1, 1);
    settle();
    RST_N = 1'b0;
    #1;
    reset_checks("midrst");
    model_val = 0;
    edge_cnt  = 0;
    CE = 1'b0; CLR = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    RST_N = 1'b1;

    // Up wrap from 9999.
    pulses(9999, 1'b1, 0);
    settle();
    check("count_9999", 32'(COUNT), 32'h9999);
    step(1'b1, 1'b1, 1'b0);
    settle();
    check("wrap_up_count", 32'(COUNT), 32'h0000);
    check("wrap_up_carry", 32'(CARRY), 32'h1);
    step(1'b0, 1'b1, 1'b0);

    // Down wrap from 0, then CLR beating CE.
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);

    // Scan of 0307 with leading-zero blanking.
    pulses(307, 1'b1, 0);
    repeat (20) step(1'b0, 1'b1, 1'b0);

    // CE held high across scanning.
    step(1'b0, 1'b1, 1'b1);
    repeat (25) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    settle();
    check("count_25", 32'(COUNT), 32'h0025);

    // Random traffic, including wraps near 0 in the down direction.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 31) == 0));
    end
    step(1'b0, 1'b1, 1'b0);
    settle();
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
